// File: rtl/sc_pkg.sv
// sc_pkg: types shared by the note matcher and the scorer.
//   TICK_W  - width of song-time / note-time values, in 10 ms ticks
//   LANE_W  - width of a fret lane index
//   note_t  - one pending chart note {lane, target tick}
//   state_e - song transport state
package sc_pkg;
  localparam int TICK_W = 16;
  localparam int LANE_W = 3;

  typedef struct packed {
    logic [LANE_W-1:0] lane;
    logic [TICK_W-1:0] tgt;
  } note_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  function automatic logic [TICK_W-1:0] abs_diff(input logic [TICK_W-1:0] a,
                                                 input logic [TICK_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction
endpackage

// File: rtl/sc_note_fifo.sv
// sc_note_fifo: synchronous show-ahead FIFO of pending chart notes.
//   clk, rst_n : clock, async active-low reset
//   clr_i      : flush (wins over push/pop that cycle)
//   push_i     : write din_i (ignored when full)
//   din_i      : note to store
//   pop_i      : drop head (ignored when empty)
//   head_o     : oldest stored note, valid while !empty_o
//   full_o     : no free entry
//   empty_o    : no stored note
module sc_note_fifo
  import sc_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  clr_i,
  input  logic  push_i,
  input  note_t din_i,
  input  logic  pop_i,
  output note_t head_o,
  output logic  full_o,
  output logic  empty_o
);
  localparam int AW = $clog2(DEPTH);

  note_t         mem_q [DEPTH];
  logic [AW:0]   wr_q, rd_q;
  logic          do_push, do_pop;

  // Extra pointer bit tells full from empty when the indices coincide.
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign head_o  = mem_q[rd_q[AW-1:0]];

  assign do_push = push_i && !full_o && !clr_i;
  assign do_pop  = pop_i && !empty_o && !clr_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else if (clr_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
  end
endmodule

// File: rtl/sc_note_match.sv
// sc_note_match: song clock + fret-press matcher against the head chart note.
//   clk, rst_n       : clock, async active-low reset
//   start_i/pause_i/clear_i : transport pulses (clear outranks the others)
//   note_valid_i/note_ready_o, note_lane_i, note_time_i : chart note push
//   btn_i            : raw asynchronous fret buttons
//   en_o, dt_o       : one-cycle hit strobe and |song_time - note_time|
//   miss_o           : one-cycle strobe, head note expired unplayed
//   lane_out_o       : lane of the last retired note
//   song_time_o      : current tick count (saturating)
//   running_o        : transport in RUN
module sc_note_match
  import sc_pkg::*;
#(
  parameter int TICK_DIV = 1_000_000,
  parameter int WINDOW   = 100,
  parameter int DEPTH    = 8,
  parameter int LANES    = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              pause_i,
  input  logic              clear_i,
  input  logic              note_valid_i,
  output logic              note_ready_o,
  input  logic [LANE_W-1:0] note_lane_i,
  input  logic [TICK_W-1:0] note_time_i,
  input  logic [LANES-1:0]  btn_i,
  output logic              en_o,
  output logic [TICK_W-1:0] dt_o,
  output logic              miss_o,
  output logic [LANE_W-1:0] lane_out_o,
  output logic [TICK_W-1:0] song_time_o,
  output logic              running_o
);
  localparam int            PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

  state_e            state_q;
  logic [PW-1:0]     pre_q;
  logic [TICK_W-1:0] time_q, dt_q;
  logic [LANE_W-1:0] lane_q;
  logic              en_q, miss_q;

  // Button synchronizers plus one history stage for rising-edge detect.
  logic [LANES-1:0] sync1_q, sync2_q, hist_q, press;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      hist_q  <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  assign press = sync2_q & ~hist_q;

  // Lowest-index press wins; the others are dropped this cycle.
  logic              press_any;
  logic [LANE_W-1:0] press_lane;
  always_comb begin
    press_any  = 1'b0;
    press_lane = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (press[i]) begin
        press_any  = 1'b1;
        press_lane = LANE_W'(i);
      end
    end
  end

  note_t head, din;
  logic  full, empty, push, pop;

  assign din          = '{lane: note_lane_i, tgt: note_time_i};
  assign note_ready_o = !full;
  assign push         = note_valid_i && !full;

  sc_note_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (clear_i),
    .push_i (push),
    .din_i  (din),
    .pop_i  (pop),
    .head_o (head),
    .full_o (full),
    .empty_o(empty)
  );

  // Deadline kept one bit wider so notes near 0xFFFF never wrap early.
  logic [TICK_W:0]   deadline;
  logic [TICK_W-1:0] diff;
  logic              active, expired, do_miss, do_hit;

  assign deadline = {1'b0, head.tgt} + (TICK_W + 1)'(WINDOW);
  assign expired  = {1'b0, time_q} >= deadline;
  assign diff     = abs_diff(time_q, head.tgt);
  assign active   = (state_q == ST_RUN) && !clear_i && !empty;
  assign do_miss  = active && expired;
  assign do_hit   = active && !expired && press_any && (press_lane == head.lane) &&
                    (diff < TICK_W'(WINDOW));
  assign pop      = do_miss || do_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pre_q   <= '0;
      time_q  <= '0;
      en_q    <= 1'b0;
      miss_q  <= 1'b0;
      dt_q    <= '0;
      lane_q  <= '0;
    end else begin
      en_q   <= do_hit;
      miss_q <= do_miss;
      if (do_hit) dt_q <= diff;
      if (pop)    lane_q <= head.lane;

      if (clear_i) begin
        state_q <= ST_IDLE;
        pre_q   <= '0;
        time_q  <= '0;
      end else begin
        unique case (state_q)
          ST_IDLE:  if (start_i) state_q <= ST_RUN;
          ST_RUN: begin
            // The pause edge itself does not advance the prescaler.
            if (pause_i) begin
              state_q <= ST_PAUSE;
            end else if (pre_q == PRE_MAX) begin
              pre_q <= '0;
              if (time_q != '1) time_q <= time_q + 1'b1;
            end else begin
              pre_q <= pre_q + 1'b1;
            end
          end
          ST_PAUSE: if (pause_i) state_q <= ST_RUN;
          default:  state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign en_o        = en_q;
  assign miss_o      = miss_q;
  assign dt_o        = dt_q;
  assign lane_out_o  = lane_q;
  assign song_time_o = time_q;
  assign running_o   = (state_q == ST_RUN);
endmodule
